// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg
//   Shared definitions for the stopwatch datapath blocks:
//   - state_t : mode state encoding (EDIT=0, LOAD=1, PAUSE=2, RUN=3, EXPIRED=4)
//   - default digit / bit-per-digit counts
//   - bcd_max : value with every BCD digit set to 9
package stopwatch_pkg;

    typedef enum logic [2:0] {
        EDIT    = 3'd0,
        LOAD    = 3'd1,
        PAUSE   = 3'd2,
        RUN     = 3'd3,
        EXPIRED = 3'd4
    } state_t;

    localparam int unsigned DEFAULT_NUMBER_OF_DIGITS         = 4;
    localparam int unsigned DEFAULT_NUMBER_OF_BITS_PER_DIGIT = 4;

    // Builds the all-nines value digit by digit; callers truncate to their width.
    function automatic logic [63:0] bcd_max(input int unsigned digits,
                                            input int unsigned bits);
        logic [63:0] result;
        result = '0;
        for (int unsigned i = 0; i < digits; i++) begin
            result = (result << bits) | 64'd9;
        end
        return result;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler
//   Divides the board clock down to the counter step rate.
//   Counts 0..DIVISOR-1 while run is high, holds its value while run is low,
//   and returns to 0 whenever clear is high (clear wins over run).
// Ports:
//   clk    in   board clock
//   rst_n  in   asynchronous active-low reset
//   run    in   advance the count this cycle
//   clear  in   force the count back to 0
//   tick   out  high for one cycle while at the terminal count and running
module tick_prescaler #(
    parameter int unsigned DIVISOR = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clear,
    output logic tick
);

    localparam int unsigned   CW   = $clog2(DIVISOR);
    localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (run) begin
            count <= (count == LAST) ? '0 : count + CW'(1);
        end
    end

    assign tick = run && !clear && (count == LAST);

endmodule

// File: rtl/stopwatch_mode_controller.sv
// stopwatch_mode_controller
//   Mode sequencer for the stopwatch datapath: edit / load / paused / running /
//   expired. Detects rising edges on the debounced buttons, paces counter steps
//   with a prescaler, and stops at 0 (counting down) or all-nines (counting up).
// Ports:
//   clk, rst_n       board clock, asynchronous active-low reset
//   start_stop       button level: run / pause
//   mode             button level: toggle edit side / run side
//   clear            button level: clear the counter
//   dir              1 = count up, 0 = count down
//   set_value        editor value (loaded by the counter itself on count_load)
//   count_value      counter's current value, used for the limit check
//   set_en           editor key handling enable
//   count_en         one-cycle step pulse
//   count_up         registered direction
//   count_load       one-cycle load pulse
//   count_clear      one-cycle clear pulse
//   display_sel      0 = editor value, 1 = counter value
//   expired          high while in EXPIRED
//   state            encoded current state
module stopwatch_mode_controller
    import stopwatch_pkg::*;
#(
    parameter int unsigned NUMBER_OF_DIGITS            = DEFAULT_NUMBER_OF_DIGITS,
    parameter int unsigned NUMBER_OF_BITS_PER_DIGIT    = DEFAULT_NUMBER_OF_BITS_PER_DIGIT,
    parameter int unsigned BOARD_CLOCK_FREQUENCY_IN_HZ = 100_000_000,
    parameter int unsigned TICK_FREQUENCY_IN_HZ        = 100
) (
    input  logic                                                   clk,
    input  logic                                                   rst_n,
    input  logic                                                   start_stop,
    input  logic                                                   mode,
    input  logic                                                   clear,
    input  logic                                                   dir,
    input  logic [NUMBER_OF_DIGITS*NUMBER_OF_BITS_PER_DIGIT-1:0] set_value,
    input  logic [NUMBER_OF_DIGITS*NUMBER_OF_BITS_PER_DIGIT-1:0] count_value,
    output logic                                                   set_en,
    output logic                                                   count_en,
    output logic                                                   count_up,
    output logic                                                   count_load,
    output logic                                                   count_clear,
    output logic                                                   display_sel,
    output logic                                                   expired,
    output logic [2:0]                                             state
);

    localparam int unsigned  W       = NUMBER_OF_DIGITS * NUMBER_OF_BITS_PER_DIGIT;
    localparam int unsigned  DIVISOR = BOARD_CLOCK_FREQUENCY_IN_HZ / TICK_FREQUENCY_IN_HZ;
    localparam logic [W-1:0] BCD_MAX = W'(bcd_max(NUMBER_OF_DIGITS, NUMBER_OF_BITS_PER_DIGIT));

    // set_value goes straight to the counter; the controller only sequences the load.
    logic unused_set_value;
    assign unused_set_value = ^set_value;

    state_t cur_state, next_state;

    logic start_stop_prev, mode_prev, clear_prev;
    logic start_stop_edge, mode_edge, clear_edge;
    logic clear_win, mode_win, start_stop_win;
    logic tick, at_limit, prescale_clear;
    logic en_next, clear_next;
    logic [W-1:0] limit;

    assign start_stop_edge = start_stop & ~start_stop_prev;
    assign mode_edge       = mode & ~mode_prev;
    assign clear_edge      = clear & ~clear_prev;

    // Only the highest-priority edge of a cycle is acted on.
    assign clear_win      = clear_edge;
    assign mode_win       = mode_edge & ~clear_edge;
    assign start_stop_win = start_stop_edge & ~mode_edge & ~clear_edge;

    // Limit follows the registered direction, i.e. what the counter is told.
    assign limit    = count_up ? BCD_MAX : '0;
    assign at_limit = (count_value == limit);

    assign prescale_clear = clear_edge || (cur_state == EDIT) || (cur_state == LOAD);

    tick_prescaler #(
        .DIVISOR (DIVISOR)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (cur_state == RUN),
        .clear (prescale_clear),
        .tick  (tick)
    );

    always_comb begin
        next_state = cur_state;
        en_next    = 1'b0;
        clear_next = 1'b0;
        unique case (cur_state)
            EDIT: begin
                if (mode_win) next_state = LOAD;
            end
            LOAD: begin
                next_state = PAUSE;
            end
            PAUSE: begin
                if (clear_win)           clear_next = 1'b1;
                else if (mode_win)       next_state = EDIT;
                else if (start_stop_win) next_state = RUN;
            end
            RUN: begin
                if (clear_win) begin
                    // The clear also zeroes the prescaler, so a coincident tick is discarded.
                    clear_next = 1'b1;
                end else begin
                    if (start_stop_win) next_state = PAUSE;
                    if (tick) begin
                        if (!at_limit)           en_next    = 1'b1;
                        else if (!start_stop_win) next_state = EXPIRED;
                    end
                end
            end
            EXPIRED: begin
                if (clear_win) begin
                    clear_next = 1'b1;
                    next_state = PAUSE;
                end else if (mode_win) begin
                    next_state = EDIT;
                end else if (start_stop_win) begin
                    next_state = PAUSE;
                end
            end
            default: next_state = EDIT;
        endcase
    end

    // State-derived outputs are registered from next_state so they line up with state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state       <= EDIT;
            start_stop_prev <= 1'b0;
            mode_prev       <= 1'b0;
            clear_prev      <= 1'b0;
            set_en          <= 1'b1;
            display_sel     <= 1'b0;
            expired         <= 1'b0;
            count_load      <= 1'b0;
            count_clear     <= 1'b0;
            count_en        <= 1'b0;
            count_up        <= 1'b0;
        end else begin
            cur_state       <= next_state;
            start_stop_prev <= start_stop;
            mode_prev       <= mode;
            clear_prev      <= clear;
            set_en          <= (next_state == EDIT);
            display_sel     <= (next_state == PAUSE) || (next_state == RUN) ||
                               (next_state == EXPIRED);
            expired         <= (next_state == EXPIRED);
            count_load      <= (next_state == LOAD);
            count_clear     <= clear_next;
            count_en        <= en_next;
            count_up        <= dir;
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_stopwatch_mode_controller.sv
module tb_stopwatch_mode_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_stop, mode, clear, dir;
    logic [15:0] set_value, count_value;
    logic        set_en, count_en, count_up, count_load, count_clear;
    logic        display_sel, expired;
    logic [2:0]  state;

    int vectors = 0;
    int miscompares = 0;
    int n;

    always #5 clk = ~clk;

    stopwatch_mode_controller #(
        .NUMBER_OF_DIGITS            (4),
        .NUMBER_OF_BITS_PER_DIGIT    (4),
        .BOARD_CLOCK_FREQUENCY_IN_HZ (1000),
        .TICK_FREQUENCY_IN_HZ        (100)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_stop  (start_stop),
        .mode        (mode),
        .clear       (clear),
        .dir         (dir),
        .set_value   (set_value),
        .count_value (count_value),
        .set_en      (set_en),
        .count_en    (count_en),
        .count_up    (count_up),
        .count_load  (count_load),
        .count_clear (count_clear),
        .display_sel (display_sel),
        .expired     (expired),
        .state       (state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // which: 0 = start_stop, 1 = mode, 2 = clear. Returns one cycle after the edge.
    task automatic press(input int which);
        case (which)
            0: start_stop = 1'b1;
            1: mode       = 1'b1;
            default: clear = 1'b1;
        endcase
        step();
        start_stop = 1'b0;
        mode       = 1'b0;
        clear      = 1'b0;
    endtask

    // Steps until count_en is seen; returns cycles taken (limit if never seen).
    task automatic wait_en(input int limit, output int cycles);
        cycles = 0;
        do begin
            step();
            cycles++;
        end while (!count_en && cycles < limit);
    endtask

    task automatic count_pulses(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (count_en) pulses++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start_stop = 1'b0; mode = 1'b0; clear = 1'b0; dir = 1'b0;
        set_value = 16'h1234; count_value = 16'h0000;
        step(); step();

        // reset values
        check("rst_state", state, 3'd0);
        check("rst_set_en", set_en, 1);
        check("rst_display_sel", display_sel, 0);
        check("rst_pulses", {count_en, count_load, count_clear, expired, count_up}, 0);
        rst_n = 1'b1;
        step();

        // EDIT ignores start_stop; mode -> LOAD (one cycle) -> PAUSE
        press(0);
        check("edit_ignores_ss", state, 3'd0);
        step();
        press(1);
        check("load_pulse", count_load, 1);
        check("load_state", state, 3'd1);
        step();
        check("load_one_cycle", count_load, 0);
        check("pause_state", state, 3'd2);
        check("pause_set_en", set_en, 0);
        check("pause_display_sel", display_sel, 1);

        // counting up: pulses every 10, pause/resume keeps fractional count
        dir = 1'b1;
        step();
        check("count_up_reg", count_up, 1);
        press(0);
        check("run_state", state, 3'd3);
        wait_en(50, n); check("first_en", n, 10);
        wait_en(50, n); check("second_en", n, 10);
        wait_en(50, n); check("third_en", n, 10);
        step(); step(); step(); step();
        press(0);
        check("pause_again", state, 3'd2);
        count_pulses(5, n); check("no_en_in_pause", n, 0);
        press(0);
        wait_en(50, n); check("resume_en", n, 5);

        // counting down to zero
        press(0);
        dir = 1'b0; count_value = 16'h0002;
        step();
        press(2);
        check("pause_clear_pulse", count_clear, 1);
        check("pause_clear_state", state, 3'd2);
        step();
        press(0);
        wait_en(50, n); check("down_en1", n, 10);
        count_value = 16'h0001;
        wait_en(50, n); check("down_en2", n, 10);
        count_value = 16'h0000;
        count_pulses(10, n); check("no_en_at_zero", n, 0);
        check("expired_flag", expired, 1);
        check("expired_state", state, 3'd4);
        step();
        press(0);
        check("exp_ss_state", state, 3'd2);
        check("exp_ss_expired", expired, 0);

        // counting up into all-nines
        dir = 1'b1; count_value = 16'h9999;
        step();
        press(0);
        count_pulses(10, n); check("no_en_at_9999", n, 0);
        check("expired_9999", expired, 1);
        step();
        press(2);
        check("exp_clear_pulse", count_clear, 1);
        check("exp_clear_state", state, 3'd2);
        count_value = 16'h9998;
        step();
        press(0);
        wait_en(50, n); check("en_at_9998", n, 10);

        // simultaneous edges in PAUSE: only the clear acts
        step(); step(); step();
        press(0);
        check("pause_before_multi", state, 3'd2);
        step();
        start_stop = 1'b1; mode = 1'b1; clear = 1'b1;
        step();
        start_stop = 1'b0; mode = 1'b0; clear = 1'b0;
        check("multi_clear", count_clear, 1);
        check("multi_state", state, 3'd2);
        check("multi_no_load", count_load, 0);
        step();
        press(0);
        wait_en(50, n); check("multi_prescale_zero", n, 10);

        // mode ignored in RUN, then asynchronous reset mid-prescale
        step(); step(); step();
        press(1);
        check("run_ignores_mode", state, 3'd3);
        step();
        #2 rst_n = 1'b0;
        #1;
        check("async_state", state, 3'd0);
        check("async_set_en", set_en, 1);
        check("async_display_sel", display_sel, 0);
        check("async_outs", {count_en, count_load, count_clear, expired, count_up}, 0);
        #1 rst_n = 1'b1;
        step();
        check("post_rst_state", state, 3'd0);
        press(1);
        step();
        press(0);
        wait_en(50, n); check("post_rst_en", n, 10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
